fv_dp_ram_pipe: RTL and testbench
=================================

Name: fv_dp_ram_pipe

Overview:
- Single-clock, simple dual-port RAM: one write port with per-byte enables, one read port.
- Generalised successor to the team's basic byte-enabled RAM. Adds:
  - parametrised read latency;
  - read-enable / read-valid handshake;
  - selectable read-during-write policy;
  - a reset-triggered clear sequencer.
- Used as a formal/sim memory model behind bus agents and scoreboards.

Parameters:
- ADDW, 10: address width; DEEP = 2**ADDW words.
- DATW, 32: data width. Must be a multiple of 8; otherwise elaboration $error.
- RD_LAT, 1: read latency in cycles, legal 1..4; out of range gives elaboration $error.
- RDW_MODE, 0: same-address read-during-write policy. 0 = old data; 1 = new data, merged per byte.
- CLR_ON_RST, 1: 1 = zero every word after reset; 0 = contents untouched by reset.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  DATW/8  per-byte write enable; any bit set = write.
- wr_addr  in  ADDW  write address.
- d  in  DATW  write data; byte j = d[8j+7:8j].
- rd_en  in  1  read request.
- rd_addr  in  ADDW  read address, sampled when rd_en=1.
- q  out  DATW  read data.
- q_vld  out  1  q valid, single-cycle pulse per accepted read.
- busy  out  1  clear sequence in progress; requests ignored.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - q = 0, q_vld = 0, all read-pipeline valids = 0;
  - busy = CLR_ON_RST;
  - clear counter = 0;
  - state = CLEAR if CLR_ON_RST, else READY.
- FSM states: CLEAR, READY.
  - CLEAR: writes all-zero to word clr_cnt each cycle and increments clr_cnt. On clr_cnt == DEEP-1, the final write is done and state goes to READY.
  - Clear therefore takes exactly DEEP cycles after rst deasserts.
  - busy = (state == CLEAR).
  - While busy: we and rd_en are ignored (no user write, no read accepted).
  - READY: stays in READY until rst.
- Reset mid-clear: state returns to CLEAR and clr_cnt restarts at 0. Memory contents are not otherwise touched.
- rst during READY: behaves as a full reset; re-clears if CLR_ON_RST.
- Write: at the edge, mem[wr_addr] byte j <= d byte j for each we[j] = 1. Bytes with we[j] = 0 keep their value.
- Read accept: rd_en = 1 and not busy at edge t.
  - q and q_vld = 1 are presented after edge t + RD_LAT - 1, i.e. visible in cycle t + RD_LAT.
  - RD_LAT = 1 means a registered output.
- Throughput: one read per cycle. Back-to-back reads produce contiguous q_vld in request order.
- q holds its last value while q_vld = 0.
- Read data is captured at edge t. Writes in later cycles do not alter an in-flight read.
- Same-cycle read and write to the same address:
  - RDW_MODE 0: returns pre-write contents.
  - RDW_MODE 1: bytes with we[j] = 1 return d byte j; other bytes return old contents.
- Different addresses in the same cycle: fully independent.
- Addresses cannot be out of range (DEEP = 2**ADDW); no wrap logic.
- rst during an in-flight read: the read is discarded and q_vld stays 0.

Optional Feature:
- Macro: FV_DP_RAM_PARITY_EN.
- Defined:
  - one even-parity bit is stored per byte;
  - extra input par_flip [DATW/8] inverts the stored parity of the written byte j when we[j] & par_flip[j];
  - extra output par_err [DATW/8], reset 0, is valid with q_vld: par_err[j] = 1 if the recomputed parity of q byte j mismatches the stored bit;
  - clear writes correct parity (0).
  - RDW_MODE 1 merged bytes use parity of d and are never flagged.
- Undefined: no parity storage, and par_flip / par_err ports are absent.

Test Plan:
1. ADDW=4, CLR_ON_RST=1: hold rst 2 cycles, release.
   - busy = 1 for exactly 16 cycles, then 0.
   - Reading addresses 0..15 returns q = 0 each time.
2. RD_LAT=2: write 0xDEADBEEF to addr 3 with we=4'b1111, then d=0x00005500 with we=4'b0010; rd_en addr 3 at cycle t.
   - q = 0xDEAD55EF with q_vld = 1 in cycle t+2 only.
3. addr 5 = 0x11111111; same cycle: write 0xAAAAAAAA with we=4'b0011 and read addr 5.
   - RDW_MODE 0: q = 0x11111111.
   - RDW_MODE 1: q = 0x1111AAAA.
   - Subsequent read: 0x1111AAAA.
4. ADDW=4: assert rst when clr_cnt = 7; rd_en asserted throughout.
   - After release, busy = 1 for 16 more cycles.
   - No q_vld while busy.
5. RD_LAT=3: stream rd_en for addrs 0,1,2,3 on 4 consecutive cycles.
   - q_vld high for 4 consecutive cycles with data in order.
   - A write to addr 1 issued one cycle after its read does not change the returned data.
6. FV_DP_RAM_PARITY_EN: write 0x12345678 to addr 2 with par_flip = 4'b0001, then read.
   - q = 0x12345678 and par_err = 4'b0001 with q_vld.
   - Rewriting with par_flip = 0 and reading gives par_err = 0.

Source files
------------

// File: rtl/fv_dp_ram_pipe.sv
// Simple dual-port byte-enabled RAM with pipelined read handshake and a
// reset-triggered clear sequencer. Define FV_DP_RAM_PARITY_EN for per-byte parity.
module fv_dp_ram_pipe #(
    parameter int ADDW       = 10,
    parameter int DATW       = 32,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATW/8-1:0] we,
    input  logic [ADDW-1:0]   wr_addr,
    input  logic [DATW-1:0]   d,
    input  logic              rd_en,
    input  logic [ADDW-1:0]   rd_addr,
`ifdef FV_DP_RAM_PARITY_EN
    input  logic [DATW/8-1:0] par_flip,
    output logic [DATW/8-1:0] par_err,
`endif
    output logic [DATW-1:0]   q,
    output logic              q_vld,
    output logic              busy
);
    localparam int NB   = DATW / 8;
    localparam int DEEP = 2 ** ADDW;
    localparam int LAT  = (RD_LAT < 1) ? 1 : ((RD_LAT > 4) ? 4 : RD_LAT);

    if (DATW % 8 != 0) begin : g_bad_datw
        $error("fv_dp_ram_pipe: DATW (%0d) must be a multiple of 8", DATW);
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $error("fv_dp_ram_pipe: RD_LAT (%0d) must be within 1..4", RD_LAT);
    end

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam state_e RST_STATE = (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;

    function automatic logic [NB-1:0] byte_parity(input logic [DATW-1:0] v);
        logic [NB-1:0] p;
        p = '0;
        for (int j = 0; j < NB; j++) begin
            p[j] = ^v[8*j +: 8];
        end
        return p;
    endfunction

    state_e          state_q, state_d;
    logic [ADDW-1:0] clr_cnt_q, clr_cnt_d;
    logic            busy_q, busy_d;
    logic            clr_wr_s;
    logic            usr_go_s;
    logic [NB-1:0]   mem_wen_s;
    logic [ADDW-1:0] mem_waddr_s;
    logic [DATW-1:0] mem_wdata_s;
    logic [DATW-1:0] mem_q [DEEP];
    logic            rd_acc_s;
    logic            rdw_hit_s;
    logic [NB-1:0]   rd_merge_s;
    logic [DATW-1:0] rd_old_s;
    logic [DATW-1:0] rd_data_s;
    logic [LAT-1:0]  pipe_vld_q, pipe_vld_d;
    logic [DATW-1:0] pipe_dat_q [LAT];
    logic [DATW-1:0] pipe_dat_d [LAT];

    // State register, clear counter and registered busy flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_STATE;
            clr_cnt_q <= '0;
            busy_q    <= (CLR_ON_RST != 0);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state logic: the clear ends after writing the last word
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (&clr_cnt_q) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = RST_STATE;
        endcase
    end

    // FSM outputs: clear write strobe, counter advance and next busy value
    always_comb begin
        clr_wr_s  = 1'b0;
        clr_cnt_d = '0;
        case (state_q)
            ST_CLEAR: begin
                clr_wr_s  = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDW'(1);
            end
            ST_READY: begin
                clr_wr_s  = 1'b0;
                clr_cnt_d = '0;
            end
            default: begin
                clr_wr_s  = 1'b0;
                clr_cnt_d = '0;
            end
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // Write-port mux: clear sequencer owns the port while busy
    always_comb begin
        usr_go_s = ~rst & ~busy_q;
        if (clr_wr_s && !rst) begin
            mem_wen_s   = '1;
            mem_waddr_s = clr_cnt_q;
            mem_wdata_s = '0;
        end else if (usr_go_s) begin
            mem_wen_s   = we;
            mem_waddr_s = wr_addr;
            mem_wdata_s = d;
        end else begin
            mem_wen_s   = '0;
            mem_waddr_s = wr_addr;
            mem_wdata_s = d;
        end
    end

    // Byte-enabled storage write; contents are never reset
    always_ff @(posedge clk) begin
        for (int j = 0; j < NB; j++) begin
            if (mem_wen_s[j]) begin
                mem_q[mem_waddr_s][8*j +: 8] <= mem_wdata_s[8*j +: 8];
            end
        end
    end

    // Read capture with optional same-address byte merge of write data
    always_comb begin
        rd_acc_s   = rd_en & ~busy_q & ~rst;
        rd_old_s   = mem_q[rd_addr];
        rdw_hit_s  = (RDW_MODE == 1) && usr_go_s && (rd_addr == wr_addr);
        rd_merge_s = '0;
        rd_data_s  = rd_old_s;
        for (int j = 0; j < NB; j++) begin
            rd_merge_s[j]       = rdw_hit_s & we[j];
            rd_data_s[8*j +: 8] = rd_merge_s[j] ? d[8*j +: 8] : rd_old_s[8*j +: 8];
        end
    end

    // Read pipeline shift; each stage keeps its data when no valid arrives
    always_comb begin
        pipe_vld_d    = '0;
        pipe_dat_d    = pipe_dat_q;
        pipe_vld_d[0] = rd_acc_s;
        pipe_dat_d[0] = rd_acc_s ? rd_data_s : pipe_dat_q[0];
        for (int k = 1; k < LAT; k++) begin
            pipe_vld_d[k] = pipe_vld_q[k-1];
            pipe_dat_d[k] = pipe_vld_q[k-1] ? pipe_dat_q[k-1] : pipe_dat_q[k];
        end
    end

    // Read pipeline registers; reset discards in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                pipe_dat_q[k] <= '0;
            end
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_dat_q <= pipe_dat_d;
        end
    end

    assign q     = pipe_dat_q[LAT-1];
    assign q_vld = pipe_vld_q[LAT-1];
    assign busy  = busy_q;

`ifdef FV_DP_RAM_PARITY_EN
    logic [NB-1:0] par_mem_q [DEEP];
    logic [NB-1:0] par_wbits_s;
    logic [NB-1:0] rd_err_s;
    logic [NB-1:0] perr_q [LAT];
    logic [NB-1:0] perr_d [LAT];

    // Stored parity bits, optionally corrupted by par_flip on user writes
    always_comb begin
        par_wbits_s = byte_parity(mem_wdata_s) ^ (par_flip & we & {NB{usr_go_s}});
        rd_err_s    = (byte_parity(rd_old_s) ^ par_mem_q[rd_addr]) & ~rd_merge_s;
    end

    // Parity storage write alongside the data bytes
    always_ff @(posedge clk) begin
        for (int j = 0; j < NB; j++) begin
            if (mem_wen_s[j]) begin
                par_mem_q[mem_waddr_s][j] <= par_wbits_s[j];
            end
        end
    end

    // Parity error flags travel with the read data
    always_comb begin
        perr_d    = perr_q;
        perr_d[0] = rd_acc_s ? rd_err_s : perr_q[0];
        for (int k = 1; k < LAT; k++) begin
            perr_d[k] = pipe_vld_q[k-1] ? perr_q[k-1] : perr_q[k];
        end
    end

    // Parity error pipeline registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LAT; k++) begin
                perr_q[k] <= '0;
            end
        end else begin
            perr_q <= perr_d;
        end
    end

    assign par_err = perr_q[LAT-1];
`endif

endmodule

// File: tb/tb_fv_dp_ram_pipe.sv
// Bench for fv_dp_ram_pipe: three instances (RD_LAT 2/3/1, old/new/new RDW) share
// one stimulus and are checked against a word-level memory model with a delivery schedule.
module tb_fv_dp_ram_pipe;
    localparam int DEEP = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  we;
    logic [3:0]  wr_addr;
    logic [31:0] d;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [3:0]  pflip;
    logic [31:0] q_w [3];
    logic [3:0]  err_w [3];
    logic [2:0]  vld_w;
    logic [2:0]  busy_w;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mdl_mem [DEEP];
    logic [3:0]  mdl_flip [DEEP];
    int          clr_left;
    int          cyc;
    logic        sch_vld [3][8];
    logic [31:0] sch_dat [3][8];
    logic [3:0]  sch_err [3][8];
    logic        exp_vld [3];
    logic [31:0] exp_q [3];
    logic [3:0]  exp_err [3];
    logic        exp_busy;

    always #5 clk = ~clk;

    fv_dp_ram_pipe #(.ADDW(4), .DATW(32), .RD_LAT(2), .RDW_MODE(0), .CLR_ON_RST(1)) u_lat2 (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .d(d),
        .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef FV_DP_RAM_PARITY_EN
        .par_flip(pflip), .par_err(err_w[0]),
`endif
        .q(q_w[0]), .q_vld(vld_w[0]), .busy(busy_w[0]));

    fv_dp_ram_pipe #(.ADDW(4), .DATW(32), .RD_LAT(3), .RDW_MODE(1), .CLR_ON_RST(1)) u_lat3 (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .d(d),
        .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef FV_DP_RAM_PARITY_EN
        .par_flip(pflip), .par_err(err_w[1]),
`endif
        .q(q_w[1]), .q_vld(vld_w[1]), .busy(busy_w[1]));

    fv_dp_ram_pipe #(.ADDW(4), .DATW(32), .RD_LAT(1), .RDW_MODE(1), .CLR_ON_RST(1)) u_lat1 (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .d(d),
        .rd_en(rd_en), .rd_addr(rd_addr),
`ifdef FV_DP_RAM_PARITY_EN
        .par_flip(pflip), .par_err(err_w[2]),
`endif
        .q(q_w[2]), .q_vld(vld_w[2]), .busy(busy_w[2]));

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit mode_of(input int i);
        return (i != 0);
    endfunction

    // One clock edge: advance the model from the driven inputs, return at the falling edge
    task automatic step();
        logic [31:0] rd;
        logic [3:0]  er;
        int          slot;
        @(posedge clk);
        if (rst) begin
            clr_left = DEEP;
            for (int i = 0; i < 3; i++) begin
                for (int s = 0; s < 8; s++) sch_vld[i][s] = 1'b0;
                exp_vld[i] = 1'b0;
                exp_q[i]   = 32'h0;
                exp_err[i] = 4'h0;
            end
        end else begin
            if (clr_left > 0) begin
                mdl_mem[DEEP - clr_left]  = 32'h0;
                mdl_flip[DEEP - clr_left] = 4'h0;
                clr_left--;
            end else begin
                if (rd_en) begin
                    for (int i = 0; i < 3; i++) begin
                        rd = mdl_mem[rd_addr];
                        er = mdl_flip[rd_addr];
                        if (mode_of(i) && rd_addr == wr_addr) begin
                            for (int j = 0; j < 4; j++) begin
                                if (we[j]) begin
                                    rd[8*j +: 8] = d[8*j +: 8];
                                    er[j] = 1'b0;
                                end
                            end
                        end
                        slot = (cyc + lat_of(i) - 1) % 8;
                        sch_vld[i][slot] = 1'b1;
                        sch_dat[i][slot] = rd;
                        sch_err[i][slot] = er;
                    end
                end
                for (int j = 0; j < 4; j++) begin
                    if (we[j]) begin
                        mdl_mem[wr_addr][8*j +: 8] = d[8*j +: 8];
                        mdl_flip[wr_addr][j] = pflip[j];
                    end
                end
            end
            for (int i = 0; i < 3; i++) begin
                slot = cyc % 8;
                exp_vld[i] = sch_vld[i][slot];
                if (exp_vld[i]) begin
                    exp_q[i]   = sch_dat[i][slot];
                    exp_err[i] = sch_err[i][slot];
                    sch_vld[i][slot] = 1'b0;
                end
            end
        end
        exp_busy = (clr_left > 0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v, input logic [3:0] be);
        we = be; wr_addr = a; d = v;
        step();
        we = 4'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (q_w[i] !== 32'h0 || vld_w[i] !== 1'b0 || busy_w[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset inst%0d: q=%h vld=%b busy=%b expected q=0 vld=0 busy=1",
                         i, q_w[i], vld_w[i], busy_w[i]);
            end
        end
    endtask

    task automatic test_clear();
        int n;
        rst = 1'b0;
        n = 0;
        while (busy_w[0] === 1'b1 && n < 40) begin
            n++;
            step();
        end
        vectors++;
        if (n != DEEP) begin
            miscompares++;
            $display("FAIL clear_len: busy cycles=%0d expected %0d", n, DEEP);
        end
        for (int a = 0; a < DEEP + 4; a++) begin
            rd_en = (a < DEEP);
            rd_addr = 4'(a);
            step();
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (vld_w[i] !== exp_vld[i] || q_w[i] !== exp_q[i] || busy_w[i] !== exp_busy) begin
                    miscompares++;
                    $display("FAIL clear_read inst%0d: q=%h vld=%b busy=%b expected q=%h vld=%b busy=%b",
                             i, q_w[i], vld_w[i], busy_w[i], exp_q[i], exp_vld[i], exp_busy);
                end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_merge_latency();
        logic exp;
        wr(4'd3, 32'hDEADBEEF, 4'b1111);
        wr(4'd3, 32'h00005500, 4'b0010);
        rd_en = 1'b1; rd_addr = 4'd3;
        for (int k = 1; k <= 5; k++) begin
            step();
            rd_en = 1'b0;
            for (int i = 0; i < 3; i++) begin
                exp = (k == lat_of(i));
                vectors++;
                if (vld_w[i] !== exp || (exp && q_w[i] !== 32'hDEAD55EF)) begin
                    miscompares++;
                    $display("FAIL latency inst%0d k=%0d: q=%h vld=%b expected vld=%b q=deadbeef-merged %h",
                             i, k, q_w[i], vld_w[i], exp, 32'hDEAD55EF);
                end
            end
        end
    endtask

    task automatic test_rdw();
        logic [31:0] exp;
        wr(4'd5, 32'h11111111, 4'b1111);
        for (int pass = 0; pass < 2; pass++) begin
            rd_en = 1'b1; rd_addr = 4'd5;
            if (pass == 0) begin
                we = 4'b0011; wr_addr = 4'd5; d = 32'hAAAAAAAA;
            end
            for (int k = 1; k <= 4; k++) begin
                step();
                rd_en = 1'b0; we = 4'h0;
                for (int i = 0; i < 3; i++) begin
                    if (k == lat_of(i)) begin
                        exp = (pass == 0 && !mode_of(i)) ? 32'h11111111 : 32'h1111AAAA;
                        vectors++;
                        if (vld_w[i] !== 1'b1 || q_w[i] !== exp) begin
                            miscompares++;
                            $display("FAIL rdw pass%0d inst%0d: q=%h vld=%b expected q=%h vld=1",
                                     pass, i, q_w[i], vld_w[i], exp);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vals [4];
        logic        exp;
        for (int a = 0; a < 4; a++) begin
            vals[a] = $urandom;
            wr(4'(a), vals[a], 4'b1111);
        end
        for (int k = 1; k <= 8; k++) begin
            rd_en = (k <= 4);
            rd_addr = 4'(k - 1);
            if (k == 3) begin
                we = 4'b1111; wr_addr = 4'd1; d = ~vals[1];
            end else begin
                we = 4'h0;
            end
            step();
            for (int i = 0; i < 3; i++) begin
                exp = (k >= lat_of(i)) && (k < lat_of(i) + 4);
                vectors++;
                if (vld_w[i] !== exp || (exp && q_w[i] !== vals[k - lat_of(i)])) begin
                    miscompares++;
                    $display("FAIL back_to_back inst%0d k=%0d: q=%h vld=%b expected vld=%b",
                             i, k, q_w[i], vld_w[i], exp);
                end
            end
        end
        rd_en = 1'b0; we = 4'h0;
    endtask

`ifdef FV_DP_RAM_PARITY_EN
    task automatic test_parity();
        logic [3:0] exp_e;
        for (int pass = 0; pass < 2; pass++) begin
            pflip = (pass == 0) ? 4'b0001 : 4'b0000;
            exp_e = pflip;
            wr(4'd2, 32'h12345678, 4'b1111);
            pflip = 4'h0;
            rd_en = 1'b1; rd_addr = 4'd2;
            for (int k = 1; k <= 4; k++) begin
                step();
                rd_en = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    if (k == lat_of(i)) begin
                        vectors++;
                        if (vld_w[i] !== 1'b1 || q_w[i] !== 32'h12345678 || err_w[i] !== exp_e) begin
                            miscompares++;
                            $display("FAIL parity pass%0d inst%0d: q=%h err=%b expected q=12345678 err=%b",
                                     pass, i, q_w[i], err_w[i], exp_e);
                        end
                    end
                end
            end
        end
    endtask
`endif

    task automatic test_reset_mid_clear();
        int n;
        rst = 1'b1; rd_en = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            rd_addr = 4'($urandom_range(0, 15));
            step();
            vectors++;
            if (vld_w !== 3'b000 || busy_w !== 3'b111) begin
                miscompares++;
                $display("FAIL mid_clear_pre c=%0d: vld=%b busy=%b expected vld=000 busy=111",
                         c, vld_w, busy_w);
            end
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (busy_w[0] === 1'b1 && n < 40) begin
            vectors++;
            if (vld_w !== 3'b000) begin
                miscompares++;
                $display("FAIL mid_clear_vld n=%0d: vld=%b expected 000", n, vld_w);
            end
            n++;
            rd_addr = 4'($urandom_range(0, 15));
            step();
        end
        rd_en = 1'b0;
        vectors++;
        if (n != DEEP) begin
            miscompares++;
            $display("FAIL mid_clear_len: busy cycles=%0d expected %0d", n, DEEP);
        end
        for (int c = 0; c < 4; c++) begin
            step();
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (vld_w[i] !== exp_vld[i] || q_w[i] !== exp_q[i] || busy_w[i] !== exp_busy) begin
                    miscompares++;
                    $display("FAIL mid_clear_drain inst%0d: q=%h vld=%b expected q=%h vld=%b",
                             i, q_w[i], vld_w[i], exp_q[i], exp_vld[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            rst     = ($urandom_range(0, 79) == 0);
            we      = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            wr_addr = 4'($urandom);
            d       = $urandom;
            rd_en   = ($urandom_range(0, 9) < 6);
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom);
            pflip   = 4'($urandom);
            step();
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (vld_w[i] !== exp_vld[i] || q_w[i] !== exp_q[i] || busy_w[i] !== exp_busy) begin
                    miscompares++;
                    $display("FAIL random inst%0d cyc=%0d: q=%h vld=%b busy=%b expected q=%h vld=%b busy=%b",
                             i, cyc, q_w[i], vld_w[i], busy_w[i], exp_q[i], exp_vld[i], exp_busy);
                end
`ifdef FV_DP_RAM_PARITY_EN
                if (exp_vld[i] && err_w[i] !== exp_err[i]) begin
                    miscompares++;
                    $display("FAIL random_par inst%0d cyc=%0d: err=%b expected %b",
                             i, cyc, err_w[i], exp_err[i]);
                end
`endif
            end
        end
        rst = 1'b0; we = 4'h0; rd_en = 1'b0; pflip = 4'h0;
    endtask

    initial begin
        rst = 1'b1; we = 4'h0; wr_addr = 4'h0; d = 32'h0;
        rd_en = 1'b0; rd_addr = 4'h0; pflip = 4'h0;
        cyc = 0; clr_left = 0; exp_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 8; s++) sch_vld[i][s] = 1'b0;
            exp_vld[i] = 1'b0; exp_q[i] = 32'h0; exp_err[i] = 4'h0;
        end
        test_reset();
        test_clear();
        test_merge_latency();
        test_rdw();
        test_back_to_back();
`ifdef FV_DP_RAM_PARITY_EN
        test_parity();
`endif
        test_reset_mid_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
